// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decoded pipeline state in, latch enables/clears and multdiv control out
interface pipeline_hazard_ctrl_if #(
    parameter int PERF_W = 16
);
    logic              isMul_dx;
    logic              isDiv_dx;
    logic              isLw_dx;
    logic              NOP_dx;
    logic [4:0]        rd_dx;
    logic [4:0]        rs_fd;
    logic [4:0]        rt_fd;
    logic              uses_rs_fd;
    logic              uses_rt_fd;
    logic              branch_taken_x;
    logic              md_resultRDY;
    logic              md_exception;
    logic              ena_pc;
    logic              ena_fd;
    logic              ena_dx;
    logic              ena_xm;
    logic              flush_fd;
    logic              flush_dx;
    logic              bubble_xm;
    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic              md_done;
    logic              md_err;
    logic [PERF_W-1:0] stall_count;

    modport master (
        output isMul_dx, isDiv_dx, isLw_dx, NOP_dx, rd_dx, rs_fd, rt_fd,
               uses_rs_fd, uses_rt_fd, branch_taken_x, md_resultRDY, md_exception,
        input  ena_pc, ena_fd, ena_dx, ena_xm, flush_fd, flush_dx, bubble_xm,
               ctrl_MULT, ctrl_DIV, md_done, md_err, stall_count
    );

    modport slave (
        input  isMul_dx, isDiv_dx, isLw_dx, NOP_dx, rd_dx, rs_fd, rt_fd,
               uses_rs_fd, uses_rt_fd, branch_taken_x, md_resultRDY, md_exception,
        output ena_pc, ena_fd, ena_dx, ena_xm, flush_fd, flush_dx, bubble_xm,
               ctrl_MULT, ctrl_DIV, md_done, md_err, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for load-use, taken branch and multdiv
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6,
    parameter int PERF_W     = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    pipeline_hazard_ctrl_if.slave        hz
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              err_q, err_n;
    logic [PERF_W-1:0] stall_q;
    logic              md_req;
    logic              lu_haz;

    assign md_req = (hz.isMul_dx | hz.isDiv_dx) & ~hz.NOP_dx;
    assign lu_haz = hz.isLw_dx & ~hz.NOP_dx & (hz.rd_dx != 5'd0) &
                    ((hz.uses_rs_fd & (hz.rs_fd == hz.rd_dx)) |
                     (hz.uses_rt_fd & (hz.rt_fd == hz.rd_dx)));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= err_n;
            if (!hz.ena_pc && (stall_q != {PERF_W{1'b1}}))
                stall_q <= stall_q + 1'b1;
        end
    end

    assign hz.stall_count = stall_q;

    // While reset is held the outputs stay at their free-running defaults.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        err_n        = err_q;
        hz.ena_pc    = 1'b1;
        hz.ena_fd    = 1'b1;
        hz.ena_dx    = 1'b1;
        hz.ena_xm    = 1'b1;
        hz.flush_fd  = 1'b0;
        hz.flush_dx  = 1'b0;
        hz.bubble_xm = 1'b0;
        hz.ctrl_MULT = 1'b0;
        hz.ctrl_DIV  = 1'b0;
        hz.md_done   = 1'b0;
        hz.md_err    = 1'b0;
        if (reset) begin
            case (state)
                S_IDLE: begin
                    if (hz.branch_taken_x) begin
                        hz.flush_fd = 1'b1;
                        hz.flush_dx = 1'b1;
                    end else if (md_req) begin
                        hz.ctrl_MULT = hz.isMul_dx;
                        hz.ctrl_DIV  = hz.isDiv_dx & ~hz.isMul_dx;
                        hz.ena_pc    = 1'b0;
                        hz.ena_fd    = 1'b0;
                        hz.ena_dx    = 1'b0;
                        hz.bubble_xm = 1'b1;
                        state_n      = S_BUSY;
                        cnt_n        = '0;
                    end else if (lu_haz) begin
                        hz.ena_pc   = 1'b0;
                        hz.ena_fd   = 1'b0;
                        hz.flush_dx = 1'b1;
                    end
                end
                S_BUSY: begin
                    hz.ena_pc    = 1'b0;
                    hz.ena_fd    = 1'b0;
                    hz.ena_dx    = 1'b0;
                    hz.bubble_xm = 1'b1;
                    cnt_n        = cnt + 1'b1;
                    if (hz.md_resultRDY) begin
                        state_n = S_DONE;
                        err_n   = hz.md_exception;
                    end else if (cnt == CNT_W'(MD_TIMEOUT - 1)) begin
                        state_n = S_DONE;
                        err_n   = 1'b1;
                    end
                end
                S_DONE: begin
                    hz.md_done = 1'b1;
                    hz.md_err  = err_q;
                    state_n    = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector and sequence bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    localparam int PW = 4;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_bad;

    pipeline_hazard_ctrl_if #(.PERF_W(PW)) hz ();

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6), .PERF_W(PW)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic       mul, div, lw, nop;
        logic [4:0] rd, rs, rt;
        logic       urs, urt, br;
        logic [8:0] exp;  // ena_pc,ena_fd,ena_dx,ena_xm,flush_fd,flush_dx,bubble_xm,ctrl_MULT,ctrl_DIV
    } vec_t;

    vec_t vt[13];

    function automatic logic [8:0] outs();
        return {hz.ena_pc, hz.ena_fd, hz.ena_dx, hz.ena_xm, hz.flush_fd,
                hz.flush_dx, hz.bubble_xm, hz.ctrl_MULT, hz.ctrl_DIV};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        hz.isMul_dx = 0; hz.isDiv_dx = 0; hz.isLw_dx = 0; hz.NOP_dx = 0;
        hz.rd_dx = 0; hz.rs_fd = 0; hz.rt_fd = 0;
        hz.uses_rs_fd = 0; hz.uses_rt_fd = 0; hz.branch_taken_x = 0;
        hz.md_resultRDY = 0; hz.md_exception = 0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        clear_inputs();
        tick();
        reset = 1'b1;
    endtask

    task automatic run_md(input string name, input bit is_div, input int rdy_at,
                          input bit exc, input int exp_lat, input bit exp_err);
        int n_low;
        int starts;
        int cyc;
        pulse_reset();
        hz.isMul_dx = !is_div;
        hz.isDiv_dx = is_div;
        #1;
        chk({name, "_start"}, {30'd0, hz.ctrl_MULT, hz.ctrl_DIV}, {30'd0, !is_div, is_div});
        n_low  = 0;
        starts = 0;
        for (cyc = 0; cyc < 100; cyc++) begin
            if (cyc > 0) begin
                hz.isMul_dx     = 0;
                hz.isDiv_dx     = 0;
                hz.md_resultRDY = (cyc == rdy_at);
                hz.md_exception = (cyc == rdy_at) && exc;
                #1;
                if (hz.ctrl_MULT || hz.ctrl_DIV) starts++;
            end
            if (!hz.ena_pc) n_low++;
            if (hz.md_done) break;
            tick();
        end
        chk({name, "_latency"}, cyc, exp_lat);
        chk({name, "_err"}, hz.md_err, exp_err);
        chk({name, "_low_cycles"}, n_low, exp_lat);
        chk({name, "_stall_count"}, hz.stall_count, exp_lat > 15 ? 15 : exp_lat);
        chk({name, "_extra_starts"}, starts, 0);
        clear_inputs();
        tick();
        #1;
        chk({name, "_after_done"}, {hz.md_done, hz.ena_pc}, 2'b01);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0;
        clear_inputs();
        //          mul div lw nop rd     rs     rt     urs urt br  exp
        vt[0]  = '{0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 9'b1111_000_00};
        vt[1]  = '{0, 0, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 9'b0011_010_00};
        vt[2]  = '{0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 9'b1111_000_00};
        vt[3]  = '{0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 9'b1111_000_00};
        vt[4]  = '{0, 0, 1, 0, 5'd5, 5'd3, 5'd5, 1, 1, 0, 9'b0011_010_00};
        vt[5]  = '{0, 0, 1, 0, 5'd5, 5'd3, 5'd5, 1, 0, 0, 9'b1111_000_00};
        vt[6]  = '{1, 0, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 9'b0001_001_10};
        vt[7]  = '{0, 1, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 9'b0001_001_01};
        vt[8]  = '{1, 1, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0, 0, 9'b0001_001_10};
        vt[9]  = '{1, 0, 0, 1, 5'd7, 5'd0, 5'd0, 0, 0, 0, 9'b1111_000_00};
        vt[10] = '{1, 0, 0, 0, 5'd7, 5'd0, 5'd0, 0, 0, 1, 9'b1111_110_00};
        vt[11] = '{0, 0, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 1, 9'b1111_110_00};
        vt[12] = '{1, 0, 1, 0, 5'd5, 5'd5, 5'd0, 1, 0, 0, 9'b0001_001_10};

        tick();
        #1;
        chk("reset_outputs", {outs(), hz.md_done, hz.md_err}, {9'b1111_000_00, 2'b00});
        chk("reset_stall_count", hz.stall_count, 0);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            pulse_reset();
            hz.isMul_dx = vt[i].mul; hz.isDiv_dx = vt[i].div;
            hz.isLw_dx = vt[i].lw;   hz.NOP_dx = vt[i].nop;
            hz.rd_dx = vt[i].rd;     hz.rs_fd = vt[i].rs;   hz.rt_fd = vt[i].rt;
            hz.uses_rs_fd = vt[i].urs; hz.uses_rt_fd = vt[i].urt;
            hz.branch_taken_x = vt[i].br;
            #1;
            chk($sformatf("vec%0d", i), outs(), vt[i].exp);
        end

        // load-use: one stall cycle then normal flow
        pulse_reset();
        hz.isLw_dx = 1; hz.rd_dx = 5'd5; hz.rs_fd = 5'd5; hz.uses_rs_fd = 1;
        tick();
        clear_inputs();
        #1;
        chk("lu_stall_count", hz.stall_count, 1);
        chk("lu_resume", outs(), 9'b1111_000_00);

        // branch squashes mul: state stays IDLE
        pulse_reset();
        hz.isMul_dx = 1; hz.branch_taken_x = 1;
        tick();
        clear_inputs();
        #1;
        chk("br_stays_idle", outs(), 9'b1111_000_00);
        chk("br_stall_count", hz.stall_count, 0);

        run_md("mul_rdy5",   1'b0, 5,  1'b0, 6,  1'b0);
        run_md("mul_rdy1ex", 1'b0, 1,  1'b1, 2,  1'b1);
        run_md("div_timeout", 1'b1, -1, 1'b0, 41, 1'b1);
        run_md("div_rdy_at_timeout", 1'b1, 40, 1'b0, 41, 1'b0);

        // no back-to-back start from DONE
        pulse_reset();
        hz.isMul_dx = 1;
        tick();
        hz.md_resultRDY = 1;
        tick();
        hz.md_resultRDY = 0;
        #1;
        chk("b2b_done", {hz.md_done, hz.ctrl_MULT}, 2'b10);
        tick();
        chk("b2b_restart", hz.ctrl_MULT, 1);

        // reset mid-BUSY abandons the operation
        pulse_reset();
        hz.isMul_dx = 1;
        tick();
        hz.isMul_dx = 0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy_comb", {outs(), hz.md_done}, {9'b1111_000_00, 1'b0});
        tick();
        reset = 1'b1;
        #1;
        chk("rst_busy_idle", {outs(), hz.md_done}, {9'b1111_000_00, 1'b0});
        chk("rst_busy_stall", hz.stall_count, 0);
        hz.md_resultRDY = 1;
        tick();
        hz.md_resultRDY = 0;
        #1;
        chk("rst_late_rdy", {hz.md_done, hz.ena_pc}, 2'b01);

        // stall counter saturation
        pulse_reset();
        hz.isLw_dx = 1; hz.rd_dx = 5'd9; hz.rt_fd = 5'd9; hz.uses_rt_fd = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("stall_saturate", hz.stall_count, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
